// File: rtl/multicycle_cpu.sv
// Multicycle load/store core: one instruction in flight, walking IDLE/DECODE/EXECUTE/MEM/WRITEBACK.
// Small register file and data memory, both initialised by synchronous reset.
module multicycle_cpu #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  ADDR_BITS   = 5,
    parameter int  NUM_REGS    = 4,
    localparam int RSEL_W      = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = 2 + 3*RSEL_W + DATA_WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   retire,
    output logic                   carry,
    output logic                   zero,
    output logic                   err,
    input  logic [RSEL_W-1:0]      dbg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_data
);

    localparam int MEM_WORDS = 2**ADDR_BITS;
    localparam int RS2_LSB   = 4 + DATA_WIDTH;
    localparam int RS1_LSB   = RS2_LSB + RSEL_W;
    localparam int RD_LSB    = RS1_LSB + RSEL_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        T_NOP   = 2'b00,
        T_ALU   = 2'b01,
        T_LOAD  = 2'b10,
        T_STORE = 2'b11
    } itype_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_PASS = 4'd5
    } op_e;

    state_e                  state_q, state_d;
    logic [INSTR_WIDTH-1:0]  ir_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q, res_q, mdr_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic                    ex_c_q, ex_ill_q;
    logic [DATA_WIDTH-1:0]   rf_q  [NUM_REGS];
    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];
    logic                    carry_q, zero_q, err_q, retire_q;

    itype_e                  in_type, ir_type;
    logic [RSEL_W-1:0]       ir_rd, ir_rs1, ir_rs2;
    logic [DATA_WIDTH-1:0]   ir_off;
    logic [3:0]              ir_op;

    logic                    accept;
    logic                    dec_en, ex_en, mem_en, rf_we, mem_we, flag_we, retire_d;

    logic [DATA_WIDTH:0]     sum_w;
    logic [DATA_WIDTH-1:0]   alu_res, wb_data;
    logic                    alu_c, alu_ill;
    logic [ADDR_BITS-1:0]    mem_addr;

    assign in_type = itype_e'(instr[INSTR_WIDTH-1 -: 2]);
    assign ir_type = itype_e'(ir_q[INSTR_WIDTH-1 -: 2]);
    assign ir_rd   = ir_q[RD_LSB  +: RSEL_W];
    assign ir_rs1  = ir_q[RS1_LSB +: RSEL_W];
    assign ir_rs2  = ir_q[RS2_LSB +: RSEL_W];
    assign ir_off  = ir_q[4 +: DATA_WIDTH];
    assign ir_op   = ir_q[3:0];

    assign accept  = instr_valid && instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:      state_d = (accept && in_type != T_NOP) ? S_DECODE : S_IDLE;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = (ir_type == T_ALU) ? S_WRITEBACK : S_MEM;
            S_MEM:       state_d = (ir_type == T_LOAD) ? S_WRITEBACK : S_IDLE;
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        instr_ready = (state_q == S_IDLE) && !rst;
        dec_en      = (state_q == S_DECODE);
        ex_en       = (state_q == S_EXECUTE);
        mem_en      = (state_q == S_MEM);
        rf_we       = (state_q == S_WRITEBACK);
        flag_we     = (state_q == S_WRITEBACK) && (ir_type == T_ALU);
        mem_we      = (state_q == S_MEM) && (ir_type == T_STORE);
        retire_d    = rf_we || mem_we || (accept && in_type == T_NOP);
    end

    assign sum_w    = {1'b0, a_q} + {1'b0, b_q};
    assign mem_addr = ADDR_BITS'(a_q + ir_off);
    assign wb_data  = (ir_type == T_LOAD) ? mdr_q : res_q;

    always_comb begin
        alu_res = '0;
        alu_c   = carry_q;
        alu_ill = 1'b0;
        case (ir_op)
            OP_ADD:  begin alu_res = sum_w[DATA_WIDTH-1:0]; alu_c = sum_w[DATA_WIDTH]; end
            OP_SUB:  begin alu_res = a_q - b_q;             alu_c = (a_q < b_q);       end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_PASS: alu_res = b_q;
            default: alu_ill = 1'b1;
        endcase
    end

    // Pipeline-internal holding registers; their contents are don't-care outside their state
    always_ff @(posedge clk) begin
        if (accept) ir_q <= instr;
        if (dec_en) begin
            a_q <= rf_q[ir_rs1];
            b_q <= rf_q[ir_rs2];
        end
        if (ex_en) begin
            res_q    <= alu_res;
            ex_c_q   <= alu_c;
            ex_ill_q <= alu_ill;
            addr_q   <= mem_addr;
        end
        if (mem_en) mdr_q <= mem_q[addr_q];
    end

    // Architectural state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= DATA_WIDTH'(i);
            for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            retire_q <= retire_d;
            if (rf_we) rf_q[ir_rd] <= wb_data;
            if (mem_we) mem_q[addr_q] <= b_q;
            if (flag_we) begin
                zero_q  <= (wb_data == '0);
                carry_q <= ex_c_q;
                if (ex_ill_q) err_q <= 1'b1;
            end
        end
    end

    assign retire   = retire_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign err      = err_q;
    assign dbg_data = rf_q[dbg_sel];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Randomised bench for multicycle_cpu against an architectural model (arrays + flags).
`timescale 1ns/100ps
module tb_multicycle_cpu;

    localparam int DW = 8;
    localparam int AB = 5;
    localparam int NR = 4;
    localparam int RS = 2;
    localparam int IW = 2 + 3*RS + DW + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] instr = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready, retire, carry, zero, err;
    logic [RS-1:0] dbg_sel = '0;
    logic [DW-1:0] dbg_data;

    int checks = 0;
    int fails  = 0;

    int m_rf  [NR];
    int m_mem [2**AB];
    int m_c, m_z, m_e;

    multicycle_cpu #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .retire(retire), .carry(carry), .zero(zero),
        .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #10 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int t, rd, rs1, rs2, off, op);
        return {2'(t), RS'(rd), RS'(rs1), RS'(rs2), DW'(off), 4'(op)};
    endfunction

    task automatic peek(input int sel, output int val);
        dbg_sel = RS'(sel);
        #1 val = int'(dbg_data);
    endtask

    task automatic check_state();
        int v;
        check("carry", carry, m_c);
        check("zero", zero, m_z);
        check("err", err, m_e);
        for (int r = 0; r < NR; r++) begin
            peek(r, v);
            check($sformatf("reg%0d", r), v, m_rf[r]);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_rf[r] = r % 256;
        for (int k = 0; k < 2**AB; k++) m_mem[k] = 0;
        m_c = 0; m_z = 0; m_e = 0;
    endtask

    // Architectural effect of one instruction; returns its accept-to-retire latency
    task automatic model_exec(input int t, rd, rs1, rs2, off, op, output int lat);
        int a, b, r, addr;
        a = m_rf[rs1];
        b = m_rf[rs2];
        addr = ((a + off) % 256) % (2**AB);
        lat = 1;
        case (t)
            1: begin
                lat = 4;
                case (op)
                    0: begin r = a + b; m_c = (r > 255) ? 1 : 0; r = r % 256; end
                    1: begin m_c = (a < b) ? 1 : 0; r = (a - b + 256) % 256; end
                    2: r = a & b;
                    3: r = a | b;
                    4: r = a ^ b;
                    5: r = b;
                    default: begin r = 0; m_e = 1; end
                endcase
                m_z = (r == 0) ? 1 : 0;
                m_rf[rd] = r;
            end
            2: begin lat = 5; m_rf[rd] = m_mem[addr]; end
            3: begin lat = 4; m_mem[addr] = b; end
            default: lat = 1;
        endcase
    endtask

    task automatic send(input logic [IW-1:0] w, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = instr_ready;
        if (!ok) begin
            check("ready_timeout", 0, 1);
            return;
        end
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = IW'($urandom);
    endtask

    task automatic run(input int t, rd, rs1, rs2, off, op);
        bit ok, got;
        int lat, n;
        send(enc(t, rd, rs1, rs2, off, op), ok);
        if (!ok) return;
        model_exec(t, rd, rs1, rs2, off, op, lat);
        n = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            got = retire;
        end
        check($sformatf("latency_t%0d", t), got ? n : 99, lat);
        check("ready_at_retire", instr_ready, 1);
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", instr_ready, 0);
        check("rst_retire", retire, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_state();
        @(negedge clk);
        check("ready_after_rst", instr_ready, 1);
    endtask

    initial begin
        int v, t, op;
        bit ok;
        do_reset();

        run(1, 1, 2, 3, 0, 0);
        peek(1, v);  check("add_r1_is_5", v, 5);
        run(3, 0, 1, 3, 4, 0);
        run(2, 0, 1, 0, 4, 0);
        peek(0, v);  check("load_r0_is_3", v, 3);
        run(0, 2, 1, 3, 77, 9);

        do_reset();
        run(1, 0, 1, 2, 0, 1);
        peek(0, v);  check("sub_r0_ff", v, 255);
        check("sub_borrow", carry, 1);
        run(1, 0, 2, 2, 0, 1);
        check("sub_zero", zero, 1);
        run(3, 0, 0, 3, 1, 0);
        for (int k = 0; k < 4; k++) run(1, 2, 2, 2, 0, 0);
        run(1, 2, 2, 1, 0, 1);
        peek(2, v);  check("r2_is_31", v, 31);
        run(2, 0, 2, 0, 2, 0);
        peek(0, v);  check("wrap_load", v, 3);
        run(1, 3, 1, 2, 0, 10);
        check("illegal_err", err, 1);
        run(1, 1, 1, 1, 0, 0);
        check("err_sticky", err, 1);

        for (int k = 0; k < 250; k++) begin
            t  = $urandom_range(0, 3);
            op = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
            run(t, $urandom_range(0, NR-1), $urandom_range(0, NR-1), $urandom_range(0, NR-1),
                $urandom_range(0, 255), op);
        end

        do_reset();
        send(enc(3, 0, 1, 3, 4, 0), ok);
        @(negedge clk);
        do_reset();
        run(2, 0, 1, 0, 4, 0);
        peek(0, v);  check("aborted_store", v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
